// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the HPS status-line input PIO: register map,
// edge-mode encodings and the per-bit edge detector.
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_ANY  = 0;
    localparam int EDGE_RISE = 1;
    localparam int EDGE_FALL = 2;

    function automatic logic edge_bit(input int mode, input logic cur, input logic prev);
        logic result;
        case (mode)
            EDGE_RISE: result = cur & ~prev;
            EDGE_FALL: result = ~cur & prev;
            default:   result = cur ^ prev;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/soc_system_pio_debounce.sv
// One input bit: synchroniser chain followed by an optional debounce filter
// that only accepts a new level after it has been stable FILTER_CYCLES cycles.
module soc_system_pio_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_filtered
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_bypass
            assign o_filtered = w_sync;
        end else begin : g_filter
            localparam int CW = ($clog2(FILTER_CYCLES + 1) < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

            logic [CW-1:0] r_cnt;
            logic          r_filtered;

            // Any return to the accepted level restarts the stability count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt      <= '0;
                    r_filtered <= 1'b0;
                end else if (w_sync == r_filtered) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_filtered <= w_sync;
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign o_filtered = r_filtered;
        end
    endgenerate

endmodule

// File: rtl/soc_system_pio_edge_irq.sv
// Avalon-MM input PIO with per-bit edge capture and a maskable level interrupt;
// addresses 0 and 3 keep the layout of the older fixed 8-bit any-edge PIO.
module soc_system_pio_edge_irq
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0,
    parameter int EDGE_TYPE     = 0,
    parameter int BIT_CLEAR     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_filtered;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_capture_next;
    logic [WIDTH-1:0] w_wdata;
    logic [31:0]      w_rd_mux;
    logic             w_wr;
    logic             w_wr_mask;
    logic             w_wr_edge;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_irq_mask;
    logic [31:0]      r_readdata;
    logic             r_irq;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            soc_system_pio_debounce #(
                .SYNC_STAGES   (SYNC_STAGES),
                .FILTER_CYCLES (FILTER_CYCLES)
            ) u_debounce (
                .clk        (clk),
                .reset      (reset),
                .i_async    (in_port[gi]),
                .o_filtered (w_filtered[gi])
            );

            assign w_edge[gi] = edge_bit(EDGE_TYPE, w_filtered[gi], r_prev[gi]);
        end

        if (WIDTH < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    assign w_wdata   = writedata[WIDTH-1:0];
    assign w_wr      = chipselect & ~write_n;
    assign w_wr_mask = w_wr & (address == ADDR_MASK);
    assign w_wr_edge = w_wr & (address == ADDR_EDGE);

    // Bit-clear mode lets a new edge survive a simultaneous clear; legacy mode wipes everything.
    always_comb begin
        w_capture_next = r_edge_capture;
        if (BIT_CLEAR != 0) begin
            w_capture_next = (r_edge_capture & ~(w_wr_edge ? w_wdata : '0)) | w_edge;
        end else if (w_wr_edge) begin
            w_capture_next = '0;
        end else begin
            w_capture_next = r_edge_capture | w_edge;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_filtered;
            ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edge_capture;
            default:   w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev         <= '0;
            r_edge_capture <= '0;
            r_irq_mask     <= '0;
            r_readdata     <= '0;
            r_irq          <= 1'b0;
        end else begin
            r_prev         <= w_filtered;
            r_edge_capture <= w_capture_next;
            if (w_wr_mask) begin
                r_irq_mask <= w_wdata;
            end
            r_readdata     <= w_rd_mux;
            r_irq          <= |(r_edge_capture & r_irq_mask);
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_soc_system_pio_edge_irq.sv
// Directed bench for the edge-capture PIO; four instances cover the default,
// legacy-clear, falling-edge and debounced configurations.
module tb_soc_system_pio_edge_irq;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    logic [7:0]  in0, in1, in2, in3;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        irq0, irq1, irq2, irq3;

    int vec;
    int miss;

    soc_system_pio_edge_irq u_def (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in0), .irq(irq0)
    );

    soc_system_pio_edge_irq #(.BIT_CLEAR(0)) u_legacy (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .in_port(in1), .irq(irq1)
    );

    soc_system_pio_edge_irq #(.EDGE_TYPE(2)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in2), .irq(irq2)
    );

    soc_system_pio_edge_irq #(.FILTER_CYCLES(4)) u_filt (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd3),
        .in_port(in3), .irq(irq3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("[tb] write addr=%0d data=%h", a, d);
    endtask

    task automatic test_reset();
        in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
        address = 2'd0;
        reset   = 1'b1;
        tick(2);
        vec++;
        if ({rd0, rd1, rd2, rd3} !== 128'h0) begin
            miss++;
            $display("FAIL reset_readdata: got %h %h %h %h expected 0", rd0, rd1, rd2, rd3);
        end
        vec++;
        if ({irq0, irq1, irq2, irq3} !== 4'b0000) begin
            miss++;
            $display("FAIL reset_irq: got %b expected 0000", {irq0, irq1, irq2, irq3});
        end
        reset   = 1'b0;
        address = 2'd2;
        tick(1);
        vec++;
        if (rd0 !== 32'h0) begin
            miss++;
            $display("FAIL reset_mask: got %h expected 00000000", rd0);
        end
        $display("[tb] test_reset done");
    endtask

    task automatic test_defaults();
        in0 = 8'h00;
        do_reset();
        address = 2'd3;
        in0 = 8'h05;
        tick(3);
        vec++;
        if (rd0 !== 32'h0) begin
            miss++;
            $display("FAIL def_capture_edge2: got %h expected 00000000", rd0);
        end
        tick(1);
        vec++;
        if (rd0 !== 32'h05) begin
            miss++;
            $display("FAIL def_capture_edge3: got %h expected 00000005", rd0);
        end
        vec++;
        if (irq0 !== 1'b0) begin
            miss++;
            $display("FAIL def_irq_masked: got %b expected 0", irq0);
        end
        address = 2'd0;
        tick(1);
        vec++;
        if (rd0 !== 32'h05) begin
            miss++;
            $display("FAIL def_data_read: got %h expected 00000005", rd0);
        end
        address = 2'd1;
        tick(1);
        vec++;
        if (rd0 !== 32'h0) begin
            miss++;
            $display("FAIL def_addr1_read: got %h expected 00000000", rd0);
        end
        $display("[tb] test_defaults done");
    endtask

    task automatic test_irq_mask();
        in0 = 8'h00;
        do_reset();
        bus_write(2'd2, 32'hFFFF_FF04);
        address = 2'd3;
        in0 = 8'h04;
        tick(3);
        vec++;
        if (irq0 !== 1'b0) begin
            miss++;
            $display("FAIL irq_early: got %b expected 0", irq0);
        end
        tick(1);
        vec++;
        if (irq0 !== 1'b1) begin
            miss++;
            $display("FAIL irq_raise: got %b expected 1", irq0);
        end
        vec++;
        if (rd0 !== 32'h04) begin
            miss++;
            $display("FAIL irq_capture: got %h expected 00000004", rd0);
        end
        bus_write(2'd3, 32'h0000_0004);
        tick(1);
        vec++;
        if (irq0 !== 1'b0) begin
            miss++;
            $display("FAIL irq_clear: got %b expected 0", irq0);
        end
        vec++;
        if (rd0 !== 32'h0) begin
            miss++;
            $display("FAIL irq_capture_cleared: got %h expected 00000000", rd0);
        end
        address = 2'd2;
        tick(1);
        vec++;
        if (rd0 !== 32'h04) begin
            miss++;
            $display("FAIL irq_mask_readback: got %h expected 00000004", rd0);
        end
        $display("[tb] test_irq_mask done");
    endtask

    task automatic test_write_collision();
        in0 = 8'h00; in1 = 8'h00;
        do_reset();
        address = 2'd3;
        in0 = 8'h01; in1 = 8'h01;
        tick(2);
        bus_write(2'd3, 32'h0000_0001);
        tick(1);
        vec++;
        if (rd0 !== 32'h01) begin
            miss++;
            $display("FAIL coll_bitclear_set_wins: got %h expected 00000001", rd0);
        end
        vec++;
        if (rd1 !== 32'h0) begin
            miss++;
            $display("FAIL coll_legacy_clear_wins: got %h expected 00000000", rd1);
        end
        in0 = 8'h03; in1 = 8'h03;
        tick(4);
        vec++;
        if ({rd0[7:0], rd1[7:0]} !== 16'h0302) begin
            miss++;
            $display("FAIL coll_second_edge: got %h %h expected 03 02", rd0[7:0], rd1[7:0]);
        end
        bus_write(2'd3, 32'h0000_0002);
        tick(1);
        vec++;
        if ({rd0[7:0], rd1[7:0]} !== 16'h0100) begin
            miss++;
            $display("FAIL coll_partial_clear: got %h %h expected 01 00", rd0[7:0], rd1[7:0]);
        end
        $display("[tb] test_write_collision done");
    endtask

    task automatic test_falling();
        in2 = 8'hFF;
        do_reset();
        address = 2'd3;
        tick(5);
        vec++;
        if (rd2 !== 32'h0) begin
            miss++;
            $display("FAIL fall_ignores_rise: got %h expected 00000000", rd2);
        end
        in2 = 8'h0F;
        tick(4);
        vec++;
        if (rd2 !== 32'hF0) begin
            miss++;
            $display("FAIL fall_capture: got %h expected 000000f0", rd2);
        end
        in2 = 8'hFF;
        tick(5);
        vec++;
        if (rd2 !== 32'hF0) begin
            miss++;
            $display("FAIL fall_return_adds_nothing: got %h expected 000000f0", rd2);
        end
        $display("[tb] test_falling done");
    endtask

    task automatic test_filter();
        in3 = 8'h00;
        do_reset();
        address = 2'd3;
        in3 = 8'h01;
        tick(3);
        in3 = 8'h00;
        tick(8);
        vec++;
        if (rd3 !== 32'h0) begin
            miss++;
            $display("FAIL filt_glitch_capture: got %h expected 00000000", rd3);
        end
        address = 2'd0;
        tick(1);
        vec++;
        if (rd3 !== 32'h0) begin
            miss++;
            $display("FAIL filt_glitch_data: got %h expected 00000000", rd3);
        end
        address = 2'd3;
        in3 = 8'h01;
        tick(7);
        vec++;
        if (rd3 !== 32'h0) begin
            miss++;
            $display("FAIL filt_capture_edge6: got %h expected 00000000", rd3);
        end
        tick(1);
        vec++;
        if (rd3 !== 32'h01) begin
            miss++;
            $display("FAIL filt_capture_edge7: got %h expected 00000001", rd3);
        end
        address = 2'd0;
        tick(1);
        vec++;
        if (rd3 !== 32'h01) begin
            miss++;
            $display("FAIL filt_data: got %h expected 00000001", rd3);
        end
        $display("[tb] test_filter done");
    endtask

    task automatic test_reset_held_high();
        in0 = 8'h80;
        do_reset();
        address = 2'd3;
        tick(3);
        vec++;
        if (rd0 !== 32'h0) begin
            miss++;
            $display("FAIL held_capture_early: got %h expected 00000000", rd0);
        end
        tick(1);
        vec++;
        if (rd0 !== 32'h80) begin
            miss++;
            $display("FAIL held_capture: got %h expected 00000080", rd0);
        end
        $display("[tb] test_reset_held_high done");
    endtask

    task automatic test_reset_mid_filter();
        in3 = 8'h00;
        do_reset();
        address = 2'd3;
        in3 = 8'h01;
        tick(4);
        reset = 1'b1;
        tick(1);
        vec++;
        if ({rd3, 31'h0, irq3} !== 64'h0) begin
            miss++;
            $display("FAIL midreset_outputs: got rd=%h irq=%b expected 0", rd3, irq3);
        end
        reset = 1'b0;
        tick(7);
        vec++;
        if (rd3 !== 32'h0) begin
            miss++;
            $display("FAIL midreset_count_restart: got %h expected 00000000", rd3);
        end
        tick(1);
        vec++;
        if (rd3 !== 32'h01) begin
            miss++;
            $display("FAIL midreset_capture: got %h expected 00000001", rd3);
        end
        $display("[tb] test_reset_mid_filter done");
    endtask

    initial begin
        vec        = 0;
        miss       = 0;
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
        tick(1);

        test_reset();
        test_defaults();
        test_irq_mask();
        test_write_collision();
        test_falling();
        test_filter();
        test_reset_held_high();
        test_reset_mid_filter();

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
